// File: rtl/pe_link_pkg.sv
// Shared link-word definitions for the overlay PE west/east links.
// The struct bit layout is the on-wire layout: valid at the MSB, then last, then payload.
package pe_link_pkg;

  localparam int EAST_WIDTH    = 130;
  localparam int PAYLOAD_WIDTH = EAST_WIDTH - 2;
  localparam int VALID_BIT     = EAST_WIDTH - 1;
  localparam int LAST_BIT      = EAST_WIDTH - 2;
  localparam int CREDIT_BIT    = 0;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } link_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with a registered, first-word-fall-through head.
// Storage is written and read only on clock edges so it can map onto block RAM.
module pe_sync_fifo #(
  parameter int WIDTH     = 129,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
);

  localparam int                 DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     rd_data_q;
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 do_wr, do_rd;

  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign do_wr    = wr_en & ~full;
  assign do_rd    = rd_en & ~empty;
  assign rd_ptr_d = rd_ptr_q + ADDR_BITS'(do_rd);
  assign count_d  = count_q + (ADDR_BITS + 1)'(do_wr) - (ADDR_BITS + 1)'(do_rd);

  // NOTE: storage and its output register are deliberately not reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    // A word written into the slot that becomes the head must bypass the array read.
    if (do_wr && (wr_ptr_q == rd_ptr_d)) rd_data_q <= wr_data;
    else                                 rd_data_q <= mem_q[rd_ptr_d];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/pe_west_feeder.sv
// Upstream neighbour of an overlay PE: buffers a 128-bit stream and forwards it east
// as one-cycle link words, paced by credits returned on the reverse bus.
module pe_west_feeder
  import pe_link_pkg::*;
#(
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int CREDITS            = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [PAYLOAD_WIDTH-1:0]      s_data,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [EAST_WIDTH-1:0]         out_to_east,
  input  logic [EAST_WIDTH-1:0]         in_from_east,
  output logic [NUM_BRAM_ADDR_BITS:0]   fifo_count,
  output logic [3:0]                    credit_count,
  output logic                          credit_err
);

  localparam logic [3:0] CREDITS_INIT = 4'(CREDITS);

  feeder_state_t          state_q;
  logic [3:0]             credit_q, credit_d;
  logic                   err_q, err_d;
  link_word_t             out_q, out_d;
  logic                   fifo_full, fifo_empty;
  logic                   push, send, credit_ret;
  logic [PAYLOAD_WIDTH:0] head;
  logic                   unused_reverse;

  pe_sync_fifo #(
    .WIDTH    (PAYLOAD_WIDTH + 1),
    .ADDR_BITS(NUM_BRAM_ADDR_BITS)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_data({s_last, s_data}),
    .rd_en  (send),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign s_ready        = ~fifo_full;
  assign push           = s_valid & ~fifo_full;
  assign send           = (state_q == RUN) && !fifo_empty && (credit_q != '0);
  assign credit_ret     = in_from_east[CREDIT_BIT];
  assign unused_reverse = ^in_from_east[EAST_WIDTH-1:1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    out_d    = '0;
    if (send) begin
      out_d.valid   = 1'b1;
      out_d.last    = head[PAYLOAD_WIDTH];
      out_d.payload = head[PAYLOAD_WIDTH-1:0];
    end
    unique case ({send, credit_ret})
      2'b10: credit_d = credit_q - 4'd1;
      2'b01: begin
        // A return beyond the downstream buffer depth is dropped and flagged.
        if (credit_q == CREDITS_INIT) err_d    = 1'b1;
        else                          credit_d = credit_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= CREDITS_INIT;
      err_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      if (state_q == IDLE && ap_start) state_q <= RUN;
      credit_q <= credit_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign out_to_east  = out_q;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule
